// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage next-PC sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } pc_seq_state_e;

    localparam int unsigned INC_C = 2;
    localparam int unsigned INC_I = 4;

    // Wide enough to hold max(boot, flush) - 1 with one bit of headroom.
    function automatic int unsigned cnt_width(input int unsigned boot_cycles,
                                              input int unsigned flush_cycles);
        int unsigned longest;
        longest = (boot_cycles > flush_cycles) ? boot_cycles : flush_cycles;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Priority selector for the RUN-state next PC: trap, branch, stall hold, sequential step.
module next_pc_mux
    import pc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              trap_req_i,
    input  logic [ADDR_W-1:0] trap_vec_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              stall_i,
    input  logic              is_compressed_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic [ADDR_W-1:0] next_pc_o,
    output logic              redirect_o
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W - 1){1'b1}}, 1'b0};

    assign redirect_o = trap_req_i | br_taken_i;

    always_comb begin
        // Sequential step wraps modulo 2^ADDR_W by construction.
        next_pc_o = pc_i + (is_compressed_i ? ADDR_W'(INC_C) : ADDR_W'(INC_I));
        if (trap_req_i) begin
            next_pc_o = trap_vec_i & ALIGN_MASK;
        end else if (br_taken_i) begin
            next_pc_o = br_target_i & ALIGN_MASK;
        end else if (stall_i) begin
            next_pc_o = pc_i;
        end
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Fetch-stage next-PC sequencer: boot hold, sequential/redirect selection and flush window.
module pc_seq_ctrl
    import pc_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 12,
    parameter logic [ADDR_W-1:0] RESET_ADDR   = '0,
    parameter int unsigned       BOOT_CYCLES  = 4,
    parameter int unsigned       FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              is_compressed,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              trap_req,
    input  logic [ADDR_W-1:0] trap_vec,
    output logic [ADDR_W-1:0] addr_in,
    output logic [ADDR_W-1:0] pc_q,
    output logic              fetch_valid,
    output logic              flush
);

    localparam int unsigned       CNT_W      = cnt_width(BOOT_CYCLES, FLUSH_CYCLES);
    localparam logic [CNT_W-1:0]  BOOT_LAST  = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W - 1){1'b1}}, 1'b0};
    localparam logic [ADDR_W-1:0] BOOT_PC    = RESET_ADDR & ALIGN_MASK;

    pc_seq_state_e     state_q;
    logic [CNT_W-1:0]  boot_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;
    logic [ADDR_W-1:0] run_pc;
    logic              run_redirect;
    logic [ADDR_W-1:0] trap_tgt;

    assign trap_tgt = trap_vec & ALIGN_MASK;

    next_pc_mux #(
        .ADDR_W(ADDR_W)
    ) u_next_pc_mux (
        .trap_req_i     (trap_req),
        .trap_vec_i     (trap_vec),
        .br_taken_i     (br_taken),
        .br_target_i    (br_target),
        .stall_i        (stall),
        .is_compressed_i(is_compressed),
        .pc_i           (pc_q),
        .next_pc_o      (run_pc),
        .redirect_o     (run_redirect)
    );

    always_comb begin
        addr_in     = BOOT_PC;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        case (state_q)
            StRun: begin
                addr_in     = run_pc;
                fetch_valid = ~stall;
            end
            StFlush: begin
                addr_in = pc_q;
                flush   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StBoot;
            boot_cnt_q  <= '0;
            flush_cnt_q <= '0;
            pc_q        <= BOOT_PC;
        end else begin
            case (state_q)
                StBoot: begin
                    if (boot_cnt_q == BOOT_LAST) begin
                        state_q    <= StRun;
                        boot_cnt_q <= '0;
                    end else begin
                        boot_cnt_q <= boot_cnt_q + CNT_W'(1);
                    end
                end
                StRun: begin
                    pc_q <= run_pc;
                    if (run_redirect) begin
                        state_q     <= StFlush;
                        flush_cnt_q <= '0;
                    end
                end
                StFlush: begin
                    // Late trap restarts the window; branches here come from squashed work.
                    if (trap_req) begin
                        pc_q        <= trap_tgt;
                        flush_cnt_q <= '0;
                    end else if (flush_cnt_q == FLUSH_LAST) begin
                        state_q     <= StRun;
                        flush_cnt_q <= '0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q     <= StBoot;
                    boot_cnt_q  <= '0;
                    flush_cnt_q <= '0;
                    pc_q        <= BOOT_PC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed vector table plus randomized run against a cycle-count reference model.
module tb_pc_seq_ctrl;

    localparam int BOOT_N  = 4;
    localparam int FLUSH_N = 2;

    logic        clk = 1'b0;
    logic        rst, stall, is_compressed, br_taken, trap_req;
    logic [11:0] br_target, trap_vec;
    logic [11:0] addr_in, pc_q;
    logic        fetch_valid, flush;

    pc_seq_ctrl #(
        .ADDR_W      (12),
        .RESET_ADDR  (12'h000),
        .BOOT_CYCLES (BOOT_N),
        .FLUSH_CYCLES(FLUSH_N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .is_compressed(is_compressed),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .trap_req     (trap_req),
        .trap_vec     (trap_vec),
        .addr_in      (addr_in),
        .pc_q         (pc_q),
        .fetch_valid  (fetch_valid),
        .flush        (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        comp;
        logic        br;
        logic [11:0] btg;
        logic        trap;
        logic [11:0] tv;
        logic        chk;
        logic [11:0] pc;
        logic [11:0] addr;
        logic        fv;
        logic        fl;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model: remaining cycles in each window plus an integer PC.
    int m_boot_left = 0;
    int m_flush_left = 0;
    int m_pc = 0;
    bit m_known = 1'b0;

    function automatic vec_t mk(input logic r, input logic s, input logic c, input logic b,
                                input logic [11:0] bt, input logic t, input logic [11:0] v,
                                input logic k, input logic [11:0] p, input logic [11:0] a,
                                input logic f, input logic l);
        vec_t x;
        x.rst = r; x.stall = s; x.comp = c; x.br = b; x.btg = bt; x.trap = t; x.tv = v;
        x.chk = k; x.pc = p; x.addr = a; x.fv = f; x.fl = l;
        return x;
    endfunction

    function automatic int m_addr();
        if (m_boot_left > 0) return 0;
        if (m_flush_left > 0) return m_pc;
        if (trap_req) return int'(trap_vec) & 'hFFE;
        if (br_taken) return int'(br_target) & 'hFFE;
        if (stall) return m_pc;
        return (m_pc + (is_compressed ? 2 : 4)) % 4096;
    endfunction

    task automatic m_step();
        int nxt;
        nxt = m_addr();
        if (rst) begin
            m_boot_left = BOOT_N; m_flush_left = 0; m_pc = 0; m_known = 1'b1;
        end else if (m_boot_left > 0) begin
            m_boot_left--;
        end else if (m_flush_left > 0) begin
            if (trap_req) begin
                m_pc = int'(trap_vec) & 'hFFE;
                m_flush_left = FLUSH_N;
            end else begin
                m_flush_left--;
            end
        end else begin
            if (trap_req || br_taken) m_flush_left = FLUSH_N;
            m_pc = nxt;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_model();
        if (m_known) begin
            check("model_addr_in", int'(addr_in), m_addr());
            check("model_pc_q", int'(pc_q), m_pc);
            check("model_fetch_valid", int'(fetch_valid),
                  int'(m_boot_left == 0 && m_flush_left == 0 && !stall));
            check("model_flush", int'(flush), int'(m_boot_left == 0 && m_flush_left > 0));
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; stall = v.stall; is_compressed = v.comp; br_taken = v.br;
        br_target = v.btg; trap_req = v.trap; trap_vec = v.tv;
    endtask

    // Sample at the falling edge, then let the rising edge advance DUT and model together.
    task automatic finish_cycle();
        @(posedge clk);
        m_step();
        #1;
        cyc++;
    endtask

    initial begin
        vec_t v;
        // Boot: three reset cycles then four BOOT cycles at 0x000.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 'h000, 'h000, 0, 0));
        repeat (2) vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 'h000, 'h000, 0, 0));
        repeat (4) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h000, 'h000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h000, 'h004, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h004, 'h008, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h008, 'h00C, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h00C, 'h010, 1, 0));
        // Compressed mix 1,1,0 from 0x010.
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 'h010, 'h012, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 'h012, 'h014, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h014, 'h018, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h018, 'h01C, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h01C, 'h020, 1, 0));
        // Three stall cycles at 0x020.
        repeat (3) vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 'h020, 'h020, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h020, 'h024, 1, 0));
        // Odd branch target to 0xFFC, squashed branch in flush, then wrap to 0x000.
        vecs.push_back(mk(0, 0, 0, 1, 'hFFD, 0, 0, 1, 'h024, 'hFFC, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 'h003, 0, 0, 1, 'hFFC, 'hFFC, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'hFFC, 'hFFC, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'hFFC, 'h000, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 'h040, 0, 0, 1, 'h000, 'h040, 1, 0));
        repeat (2) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h040, 'h040, 0, 1));
        // Branch to 0x101 at 0x040; branches during flush are ignored.
        vecs.push_back(mk(0, 0, 0, 1, 'h101, 0, 0, 1, 'h040, 'h100, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 'h200, 0, 0, 1, 'h100, 'h100, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 'h300, 0, 0, 1, 'h100, 'h100, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h100, 'h104, 1, 0));
        // Trap beats branch; second trap one cycle into flush restarts the window.
        vecs.push_back(mk(0, 0, 0, 1, 'h100, 1, 'h800, 1, 'h104, 'h800, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h800, 'h800, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'h900, 1, 'h800, 'h800, 0, 1));
        repeat (2) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h900, 'h900, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h900, 'h904, 1, 0));
        // Redirect beats stall, then reset in flush cycle 1 restarts boot.
        vecs.push_back(mk(0, 1, 0, 1, 'h0A0, 0, 0, 1, 'h904, 'h0A0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h0A0, 'h0A0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 'h0A0, 'h0A0, 0, 1));
        repeat (4) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h000, 'h000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h000, 'h004, 1, 0));

        foreach (vecs[i]) begin
            v = vecs[i];
            drive(v);
            @(negedge clk);
            if (v.chk) begin
                check("vec_pc_q", int'(pc_q), int'(v.pc));
                check("vec_addr_in", int'(addr_in), int'(v.addr));
                check("vec_fetch_valid", int'(fetch_valid), int'(v.fv));
                check("vec_flush", int'(flush), int'(v.fl));
            end
            check_model();
            finish_cycle();
        end

        // Randomized traffic, including occasional resets and odd redirect targets.
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            is_compressed = $urandom_range(0, 1) == 1;
            br_taken      = ($urandom_range(0, 5) == 0);
            trap_req      = ($urandom_range(0, 11) == 0);
            br_target     = 12'($urandom);
            trap_vec      = 12'($urandom);
            @(negedge clk);
            check_model();
            finish_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
